// File: rtl/ft_fifo_core.sv
// ft_fifo_core: MMIO slot responder bridging the FT600 245-style synchronous FIFO bus
// to the CPU through two 18-bit word FIFOs (RX: USB->CPU, TX: CPU->USB).
// Ports:
//   clk, reset_n                  FT600 clock (system clock), async active-low reset
//   cs, read, write, addr, wr_data MMIO slot access; rd_data is combinational from addr
//   ft_rxf_n, ft_txe_n            FT600 RX-available / TX-space flags (active low)
//   ft_data_in, ft_be_in          FT600 bus input side
//   ft_data_out, ft_be_out        TX head, driven by the top level when ft_data_oe=1
//   ft_data_oe                    1 = core drives data/be (registered)
//   ft_rd_n, ft_wr_n, ft_oe_n     FT600 strobes (registered, active low)
module ft_fifo_core #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned RX_MARGIN = 4,
    parameter int unsigned MAX_BURST = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        ft_rxf_n,
    input  logic        ft_txe_n,
    input  logic [15:0] ft_data_in,
    input  logic [1:0]  ft_be_in,
    output logic [15:0] ft_data_out,
    output logic [1:0]  ft_be_out,
    output logic        ft_data_oe,
    output logic        ft_rd_n,
    output logic        ft_wr_n,
    output logic        ft_oe_n
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam int unsigned ENTRY_W = 18;

    typedef enum logic [2:0] {IDLE, RD_TA, RD, RD_END, WR} state_t;

    state_t state, state_nxt;

    logic [ENTRY_W-1:0] rx_mem [DEPTH];
    logic [ENTRY_W-1:0] tx_mem [DEPTH];
    logic [ADDR_W-1:0]  rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [CNT_W-1:0]   rx_count, tx_count, rx_free, tx_free, tx_count_nxt;
    logic [BURST_W-1:0] burst_cnt;
    logic               ctrl_enable, flush_pending, last_tx;
    logic               cpu_wr, rx_push, rx_pop, tx_push, tx_pop, do_flush;
    logic               rx_req, tx_req, burst_last;
    logic [ENTRY_W-1:0] rx_head, tx_head;
    logic               unused_bits;

    assign unused_bits = ^{read, wr_data[31:18]};

    assign cpu_wr   = cs & write;
    assign rx_pop   = cpu_wr && (addr == 5'd1) && (rx_count != '0);
    assign tx_push  = cpu_wr && (addr == 5'd2) && (tx_count != CNT_W'(DEPTH));
    // Capture uses the registered strobe, i.e. what the FT600 saw on this edge.
    assign rx_push  = (state == RD) && !ft_rd_n && !ft_rxf_n && (rx_count != CNT_W'(DEPTH));
    assign tx_pop   = (state == WR) && !ft_wr_n && !ft_txe_n;
    assign do_flush = flush_pending && (state == IDLE);

    assign rx_free = CNT_W'(DEPTH) - rx_count;
    assign tx_free = CNT_W'(DEPTH) - tx_count;
    assign rx_req  = !ft_rxf_n && (rx_free > CNT_W'(RX_MARGIN));
    assign tx_req  = !ft_txe_n && (tx_count != '0);

    assign burst_last = (rx_push || tx_pop) && (burst_cnt == BURST_W'(MAX_BURST - 1));

    assign rx_head     = rx_mem[rx_rd_ptr];
    assign tx_head     = tx_mem[tx_rd_ptr];
    assign ft_data_out = tx_head[15:0];
    assign ft_be_out   = tx_head[17:16];

    // TX occupancy after this edge; decides whether a WR burst keeps strobing.
    always_comb begin
        tx_count_nxt = tx_count;
        if (tx_push) tx_count_nxt = tx_count_nxt + CNT_W'(1);
        if (tx_pop)  tx_count_nxt = tx_count_nxt - CNT_W'(1);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic with alternating-priority arbitration
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ctrl_enable && !flush_pending) begin
                    if (rx_req && (!tx_req || last_tx)) state_nxt = RD_TA;
                    else if (tx_req)                    state_nxt = WR;
                end
            end
            RD_TA:  state_nxt = RD;
            RD: begin
                if (ft_rxf_n || (rx_free <= CNT_W'(RX_MARGIN)) || burst_last)
                    state_nxt = RD_END;
            end
            RD_END: state_nxt = IDLE;
            WR: begin
                if (ft_txe_n || (tx_count_nxt == '0) || burst_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ft_rd_n    <= 1'b1;
            ft_oe_n    <= 1'b1;
            ft_wr_n    <= 1'b1;
            ft_data_oe <= 1'b0;
        end else begin
            ft_oe_n    <= !((state_nxt == RD_TA) || (state_nxt == RD));
            ft_rd_n    <= !(state_nxt == RD);
            ft_wr_n    <= !(state_nxt == WR);
            ft_data_oe <= (state_nxt == WR);
        end
    end

    // Control register, burst length counter, last-served direction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_enable   <= 1'b0;
            flush_pending <= 1'b0;
            last_tx       <= 1'b1;
            burst_cnt     <= '0;
        end else begin
            if (do_flush) flush_pending <= 1'b0;
            if (cpu_wr && (addr == 5'd3)) begin
                ctrl_enable <= wr_data[0];
                if (wr_data[1]) flush_pending <= 1'b1;
            end
            if (state == IDLE) begin
                burst_cnt <= '0;
                if (state_nxt == RD_TA)   last_tx <= 1'b0;
                else if (state_nxt == WR) last_tx <= 1'b1;
            end else if (rx_push || tx_pop) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end
        end
    end

    // FIFO pointers and counts; a push and a pop in the same cycle cancel in the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (do_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + ADDR_W'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + ADDR_W'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_W'(1);
            else if (rx_pop && !rx_push) rx_count <= rx_count - CNT_W'(1);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + ADDR_W'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + ADDR_W'(1);
            tx_count <= tx_count_nxt;
        end
    end

    // FIFO storage (no reset needed; validity tracked by the counts)
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= {ft_be_in, ft_data_in};
        if (tx_push) tx_mem[tx_wr_ptr] <= wr_data[ENTRY_W-1:0];
    end

    // MMIO read mux
    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: begin
                rd_data[31]    = (rx_count == '0);
                rd_data[30]    = (tx_count == CNT_W'(DEPTH));
                rd_data[26:16] = 11'(rx_count);
                rd_data[10:0]  = 11'(tx_free);
            end
            5'd1: if (rx_count != '0) rd_data = 32'(rx_head);
            5'd3: rd_data = {30'b0, flush_pending, ctrl_enable};
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_ft_fifo_core.sv
// tb_ft_fifo_core: self-checking bench for ft_fifo_core with an FT600 bus model and
// scoreboards for both directions.
module tb_ft_fifo_core;

    logic        clk, reset_n, cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic        ft_rxf_n, ft_txe_n;
    logic [15:0] ft_data_in, ft_data_out;
    logic [1:0]  ft_be_in, ft_be_out;
    logic        ft_data_oe, ft_rd_n, ft_wr_n, ft_oe_n;

    int n_checks = 0;
    int n_fail   = 0;

    ft_fifo_core dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
        .ft_data_in(ft_data_in), .ft_be_in(ft_be_in),
        .ft_data_out(ft_data_out), .ft_be_out(ft_be_out), .ft_data_oe(ft_data_oe),
        .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .ft_oe_n(ft_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FT600 model state
    logic [17:0] rx_src[$];
    logic [17:0] rx_exp[$];
    logic [17:0] tx_exp[$];
    logic [17:0] tx_seen[$];
    int          dir_log[$];
    logic [17:0] tx_word;
    bit rx_take, tx_take, wr_low, rx_gap, tx_gap, oe_prev, doe_prev, tx_ready;
    int rx_since, tx_cnt, tx_limit, rx_chunk, tx_chunk, wr_low_cnt;

    // FT600 chip model: inputs change on negedge; what the DUT will see at the next
    // posedge is predicted here and applied at the following negedge.
    always @(negedge clk) begin
        if (!reset_n) begin
            rx_take = 0; tx_take = 0; wr_low = 0;
            rx_src.delete(); rx_exp.delete(); tx_seen.delete();
            ft_rxf_n = 1'b1; ft_txe_n = 1'b1;
            oe_prev = 1; doe_prev = 0;
        end else begin
            if (rx_take) begin
                rx_exp.push_back(rx_src.pop_front());
                rx_since++;
            end
            if (tx_take) begin
                tx_seen.push_back(tx_word);
                tx_cnt++;
            end
            if (wr_low) wr_low_cnt++;
            rx_gap = rx_take && (rx_chunk != 0) && ((rx_since % rx_chunk) == 0);
            tx_gap = tx_take && (tx_chunk != 0) && ((tx_cnt % tx_chunk) == 0);
            ft_rxf_n = (rx_src.size() == 0) || rx_gap;
            if (rx_src.size() != 0) {ft_be_in, ft_data_in} = rx_src[0];
            ft_txe_n = !tx_ready || tx_gap || (tx_cnt >= tx_limit);
            rx_take = !ft_rd_n && !ft_rxf_n;
            tx_take = !ft_wr_n && !ft_txe_n;
            wr_low  = !ft_wr_n;
            tx_word = {ft_be_out, ft_data_out};
            if (!ft_oe_n && oe_prev)     dir_log.push_back(0);
            if (ft_data_oe && !doe_prev) dir_log.push_back(1);
            oe_prev  = ft_oe_n;
            doe_prev = ft_data_oe;
        end
    end

    task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic cpu_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; addr = a;
        #1 d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    // Read RX head, compare with the scoreboard, pop.
    task automatic pop_and_check(input string name);
        logic [31:0] d;
        logic [17:0] e;
        cpu_read(5'd1, d);
        n_checks++;
        if (rx_exp.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %h, scoreboard empty", name, d);
        end else begin
            e = rx_exp.pop_front();
            if (d !== 32'(e)) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", name, d, 32'(e));
            end
        end
        cpu_write(5'd1, 32'd0);
    endtask

    task automatic check_tx_words(input string name, input int n);
        logic [17:0] e;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (tx_exp.size() == 0 || tx_seen.size() == 0) begin
                n_fail++;
                $display("FAIL %s[%0d]: seen %0d exp %0d words", name, i, tx_seen.size(), tx_exp.size());
            end else begin
                e = tx_exp.pop_front();
                if (tx_seen[0] !== e) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %h expected %h", name, i, tx_seen[0], e);
                end
                void'(tx_seen.pop_front());
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        cpu_read(5'd0, d);
        n_checks++;
        if (d !== 32'h8000_0200) begin n_fail++; $display("FAIL reset_status: got %h expected 80000200", d); end
        n_checks++;
        if ({ft_rd_n, ft_wr_n, ft_oe_n, ft_data_oe} !== 4'b1110) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 1110", {ft_rd_n, ft_wr_n, ft_oe_n, ft_data_oe});
        end
        cpu_read(5'd3, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        cpu_read(5'd1, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_rx_head: got %h expected 0", d); end
    endtask

    task automatic test_rx_burst();
        logic [31:0] d;
        bit found = 0;
        for (int i = 1; i <= 10; i++) rx_src.push_back({2'b11, 16'(i)});
        cpu_write(5'd3, 32'd1);
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ft_oe_n == 1'b0) found = 1;
        end
        n_checks++;
        if (!found || ft_rd_n !== 1'b1) begin
            n_fail++; $display("FAIL rx_turnaround: oe_n seen %0d rd_n %b expected 1", found, ft_rd_n);
        end
        @(negedge clk);
        n_checks++;
        if ({ft_oe_n, ft_rd_n} !== 2'b00) begin
            n_fail++; $display("FAIL rx_rd_follows: got oe_n,rd_n %b expected 00", {ft_oe_n, ft_rd_n});
        end
        for (int i = 0; i < 100 && (rx_src.size() != 0 || ft_oe_n == 1'b0); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        cpu_read(5'd0, d);
        n_checks++;
        if (d[26:16] !== 11'd10) begin n_fail++; $display("FAIL rx_count10: got %0d expected 10", d[26:16]); end
        for (int i = 0; i < 10; i++) pop_and_check("rx_burst_data");
        cpu_read(5'd0, d);
        n_checks++;
        if (d !== 32'h8000_0200) begin n_fail++; $display("FAIL rx_drained: got %h expected 80000200", d); end
        // popping an empty RX is ignored
        cpu_write(5'd1, 32'd0);
        cpu_read(5'd0, d);
        n_checks++;
        if (d !== 32'h8000_0200) begin n_fail++; $display("FAIL rx_pop_empty: got %h expected 80000200", d); end
    endtask

    task automatic test_tx_burst();
        logic [31:0] d;
        tx_ready = 0; tx_cnt = 0; tx_limit = 1000; tx_chunk = 0; wr_low_cnt = 0;
        tx_seen.delete();
        for (int i = 0; i < 5; i++) begin
            cpu_write(5'd2, 32'h2AB00 + 32'(i));
            tx_exp.push_back(18'h2AB00 + 18'(i));
        end
        cpu_read(5'd0, d);
        n_checks++;
        if (d[10:0] !== 11'd507) begin n_fail++; $display("FAIL tx_free_loaded: got %0d expected 507", d[10:0]); end
        tx_ready = 1;
        for (int i = 0; i < 100 && tx_seen.size() < 5; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_checks++;
        if (wr_low_cnt !== 5) begin n_fail++; $display("FAIL tx_wr_cycles: got %0d expected 5", wr_low_cnt); end
        check_tx_words("tx_burst_data", 5);
        n_checks++;
        if ({ft_wr_n, ft_data_oe} !== 2'b10) begin
            n_fail++; $display("FAIL tx_idle_after: got wr_n,oe %b expected 10", {ft_wr_n, ft_data_oe});
        end
    endtask

    task automatic test_tx_stall();
        logic [31:0] d;
        tx_ready = 0; tx_cnt = 0; tx_limit = 2;
        tx_seen.delete();
        for (int i = 0; i < 5; i++) begin
            cpu_write(5'd2, 32'h1C000 + 32'(i));
            tx_exp.push_back(18'h1C000 + 18'(i));
        end
        tx_ready = 1;
        for (int i = 0; i < 100 && tx_cnt < 2; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        n_checks++;
        if ({ft_wr_n, ft_data_oe, 32'(tx_seen.size())} !== {2'b10, 32'd2}) begin
            n_fail++; $display("FAIL tx_stall: wr_n %b oe %b words %0d expected 1 0 2", ft_wr_n, ft_data_oe, tx_seen.size());
        end
        cpu_read(5'd0, d);
        n_checks++;
        if (d[10:0] !== 11'd509) begin n_fail++; $display("FAIL tx_stall_free: got %0d expected 509", d[10:0]); end
        tx_limit = 1000;
        for (int i = 0; i < 100 && tx_seen.size() < 5; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        n_checks++;
        if (tx_seen.size() !== 5) begin n_fail++; $display("FAIL tx_resume_count: got %0d expected 5", tx_seen.size()); end
        check_tx_words("tx_resume_data", 5);
        tx_ready = 0;
    endtask

    task automatic test_rx_margin();
        logic [31:0] d;
        int got = 0;
        rx_chunk = 0; rx_since = 0;
        for (int i = 0; i < 600; i++) rx_src.push_back({2'b01, 16'(i)});
        for (int i = 0; i < 2000 && rx_exp.size() < 500; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        cpu_read(5'd0, d);
        n_checks++;
        if ((11'd512 - d[26:16]) > 11'd4 || ft_rd_n !== 1'b1 || rx_src.size() == 0) begin
            n_fail++; $display("FAIL rx_margin_stop: rx_count %0d rd_n %b left %0d expected free<=4 rd_n 1", d[26:16], ft_rd_n, rx_src.size());
        end
        n_checks++;
        if (32'(d[26:16]) !== 32'(rx_exp.size())) begin
            n_fail++; $display("FAIL rx_margin_count: got %0d expected %0d", d[26:16], rx_exp.size());
        end
        for (int it = 0; it < 4000 && got < 600; it++) begin
            cpu_read(5'd0, d);
            if (!d[31]) begin
                pop_and_check("rx_margin_data");
                got++;
            end
        end
        repeat (10) @(negedge clk);
        cpu_read(5'd0, d);
        n_checks++;
        if (got !== 600 || d !== 32'h8000_0200) begin
            n_fail++; $display("FAIL rx_margin_total: got %0d words status %h expected 600 80000200", got, d);
        end
    endtask

    task automatic test_full_flush();
        logic [31:0] d;
        tx_ready = 0;
        cpu_write(5'd3, 32'd0);
        for (int i = 0; i < 513; i++) cpu_write(5'd2, 32'(i));
        cpu_read(5'd0, d);
        n_checks++;
        if (d !== 32'hC000_0000) begin n_fail++; $display("FAIL tx_full: got %h expected c0000000", d); end
        cpu_write(5'd3, 32'd2);
        repeat (3) @(negedge clk);
        cpu_read(5'd0, d);
        n_checks++;
        if (d !== 32'h8000_0200) begin n_fail++; $display("FAIL flush_status: got %h expected 80000200", d); end
        cpu_read(5'd3, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL flush_selfclear: got %h expected 0", d); end
    endtask

    task automatic test_arbitration();
        logic [31:0] d;
        tx_ready = 1; tx_cnt = 0; tx_limit = 1000; tx_chunk = 2; rx_chunk = 2; rx_since = 0;
        tx_seen.delete();
        for (int i = 0; i < 6; i++) begin
            cpu_write(5'd2, 32'h35500 + 32'(i));
            tx_exp.push_back(18'h35500 + 18'(i));
            rx_src.push_back({2'b10, 16'h7700 + 16'(i)});
        end
        dir_log.delete();
        cpu_write(5'd3, 32'd1);
        for (int i = 0; i < 400 && (tx_seen.size() < 6 || rx_exp.size() < 6); i++) @(negedge clk);
        repeat (10) @(negedge clk);
        n_checks++;
        if (dir_log.size() !== 6) begin n_fail++; $display("FAIL arb_bursts: got %0d expected 6", dir_log.size()); end
        for (int i = 1; i < dir_log.size(); i++) begin
            n_checks++;
            if (dir_log[i] === dir_log[i-1]) begin
                n_fail++; $display("FAIL arb_alternate[%0d]: got dir %0d twice, expected alternation", i, dir_log[i]);
            end
        end
        check_tx_words("arb_tx_data", 6);
        for (int i = 0; i < 6; i++) pop_and_check("arb_rx_data");
        tx_chunk = 0; rx_chunk = 0; tx_ready = 0;
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d;
        bit found = 0;
        for (int i = 0; i < 20; i++) rx_src.push_back({2'b11, 16'hBEE0 + 16'(i)});
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ft_rd_n == 1'b0) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL midrst_start: rd_n never low, expected burst"); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ft_rd_n, ft_wr_n, ft_oe_n, ft_data_oe} !== 4'b1110) begin
            n_fail++; $display("FAIL midrst_strobes: got %b expected 1110", {ft_rd_n, ft_wr_n, ft_oe_n, ft_data_oe});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cpu_read(5'd0, d);
        n_checks++;
        if (d !== 32'h8000_0200) begin n_fail++; $display("FAIL midrst_status: got %h expected 80000200", d); end
        cpu_read(5'd3, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL midrst_ctrl: got %h expected 0", d); end
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        tx_ready = 0; tx_cnt = 0; tx_limit = 1000; rx_chunk = 0; tx_chunk = 0;
        rx_since = 0; wr_low_cnt = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_rx_burst();
        test_tx_burst();
        test_tx_stall();
        test_rx_margin();
        test_full_flush();
        test_arbitration();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
